case_convert_stream: RTL and testbench
======================================

# case_convert_stream

Streaming, multi-lane ASCII case converter: generalises the single-byte combinational upper-case converter to LANES bytes per beat, four run-time conversion modes, valid/ready flow control on both sides, and a saturating count of modified characters. It sits between a byte-stream source, such as a UART receive path or a memory reader, and any downstream text consumer. It sustains one beat per cycle under continuous flow.

## Interface
- LANES, 4: bytes per beat; lane i occupies bits [8i+7:8i].
- COUNT_W, 16: width of the modified-character counter.

- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  conversion mode: 00 pass, 01 upper, 10 lower, 11 toggle.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat (registered).
- in_data  in  8*LANES  input bytes.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  8*LANES  converted bytes.
- clear_count  in  1  synchronous clear of mod_count.
- mod_count  out  COUNT_W  saturating total of bytes changed.

## Operation
- Per-byte rules (bytes 0x00–0xFF; only 0x41–0x5A and 0x61–0x7A are letters):
  - Upper: a letter in 0x61–0x7A has bit 5 cleared.
  - Lower: a letter in 0x41–0x5A has bit 5 set.
  - Toggle: any letter has bit 5 inverted.
  - Pass: the byte is unchanged.
  - Non-letters, including 0x5B–0x60, 0x7B–0x7F and 0x80–0xFF, are never altered.
- mode is sampled at input acceptance (in_valid & in_ready). Changing mode affects only beats accepted afterwards.
- Buffering is a 2-entry skid buffer (main register plus skid register) with states EMPTY, ONE, TWO.
  - EMPTY → ONE on accept.
  - ONE → TWO on accept with the output stalled (out_valid & !out_ready).
  - ONE → EMPTY on output handshake without accept.
  - TWO → ONE on output handshake. The skid entry moves to main.
  - Simultaneous accept and output handshake in ONE stays in ONE, with the new beat loaded into main.
- Conversion is done before storage; out_data is always the main register.
- in_ready = 1 when the next state is not TWO. It is registered.
- mod_count increases at acceptance by the number of lanes whose byte changed (0..LANES).
  - It saturates at 2^COUNT_W−1 and never wraps.
  - clear_count with a simultaneous accept loads that beat's changed-lane count.
  - clear_count alone loads 0.
- Ordering is strictly FIFO. No beat is dropped or duplicated.

## Timing
- Reset, while rst is high and on the cycle after:
  - state EMPTY
  - out_valid = 0
  - out_data = 0
  - mod_count = 0
  - in_ready = 0 during rst, 1 on the first cycle after rst deasserts.
- Latency: a beat accepted at edge N appears on out_data with out_valid = 1 immediately after edge N, when the buffer was EMPTY or was draining the same cycle.
- Throughput: 1 beat/cycle with out_ready held high.
- Backpressure:
  - out_data and out_valid are held stable while out_valid & !out_ready.
  - in_ready drops one cycle after the second stalled accept. The skid register absorbs the in-flight beat.
- mod_count is updated at the edge of acceptance and is visible the following cycle.
- Reset mid-stream discards both buffered entries with no output handshake. It also clears mod_count.

## Structure
- Shared package case_pkg holds:
  - the mode encodings MODE_PASS, MODE_UPPER, MODE_LOWER, MODE_TOGGLE;
  - the ASCII bounds 0x41, 0x5A, 0x61, 0x7A;
  - the case bit mask 0x20.
- Sub-module case_lane, instantiated LANES times:
  - combinational, 8-bit byte plus mode in;
  - converted byte plus changed flag out.
- Top level holds the skid-buffer FSM, the lane instances, a popcount of the changed flags and the saturating counter.

## Test plan
- Upper, LANES=4, out_ready=1:
  - in_data = {0x7B,0x61,0x7A,0x40} gives out_data = {0x7B,0x41,0x5A,0x40} one cycle later;
  - mod_count = 2.
- Modes on the same beat {0x48,0x69,0x21,0xE9}:
  - pass gives an unchanged beat;
  - lower gives {0x68,0x69,0x21,0xE9};
  - toggle gives {0x68,0x49,0x21,0xE9};
  - 0xE9 is untouched in all modes.
- Backpressure:
  - stream 5 beats with out_ready = 0 from cycle 1;
  - in_ready falls after 2 accepts;
  - out_data stays at beat 0;
  - on releasing out_ready, all 5 beats emerge in order with no gaps.
- Counter with COUNT_W=4:
  - 5 all-lowercase beats in upper mode leave mod_count at 15 (saturated);
  - clear_count together with an accepted beat carrying 3 letters gives mod_count = 3.
- Reset mid-operation:
  - assert rst with the buffer in state TWO;
  - the next cycle shows out_valid = 0, mod_count = 0, in_ready = 0;
  - in_ready = 1 after deassert;
  - a fresh beat then passes with 1-cycle latency.

Source files
------------

// File: rtl/case_pkg.sv
// Shared definitions for the streaming ASCII case converter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: the mode encodings, the ASCII letter bounds and the case bit mask
// used by case_lane, and the skid-buffer state encoding used by the top level.
package case_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_UPPER  = 2'b01,
    MODE_LOWER  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  localparam logic [7:0] UPPER_LO  = 8'h41;  // 'A'
  localparam logic [7:0] UPPER_HI  = 8'h5A;  // 'Z'
  localparam logic [7:0] LOWER_LO  = 8'h61;  // 'a'
  localparam logic [7:0] LOWER_HI  = 8'h7A;  // 'z'
  localparam logic [7:0] CASE_MASK = 8'h20;  // the only bit that differs between cases

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

endpackage

// File: rtl/case_lane.sv
// Single-byte case converter for one lane of the stream.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   byte_i    - input byte
//   mode_i    - conversion mode (pass / upper / lower / toggle)
//   byte_o    - converted byte
//   changed_o - high when byte_o differs from byte_i
module case_lane
  import case_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic [1:0] mode_i,
  output logic [7:0] byte_o,
  output logic       changed_o
);

  logic is_upper;
  logic is_lower;
  logic flip;

  always_comb begin
    is_upper = (byte_i >= UPPER_LO) && (byte_i <= UPPER_HI);
    is_lower = (byte_i >= LOWER_LO) && (byte_i <= LOWER_HI);
    flip     = 1'b0;
    case (mode_i)
      MODE_UPPER:  flip = is_lower;
      MODE_LOWER:  flip = is_upper;
      MODE_TOGGLE: flip = is_upper | is_lower;
      default:     flip = 1'b0;
    endcase
  end

  // Converting a letter only ever touches the case bit, so a flip is
  // exactly "the byte changed".
  assign byte_o    = flip ? (byte_i ^ CASE_MASK) : byte_i;
  assign changed_o = flip;

endmodule

// File: rtl/case_convert_stream.sv
// Multi-lane streaming ASCII case converter with a saturating modified-byte count.
// Latency: one cycle from input acceptance to out_valid (conversion happens before storage).
// Backpressure: 2-entry skid buffer; registered in_ready drops once both entries are full.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   mode         - conversion mode, sampled when a beat is accepted
//   in_valid/in_ready/in_data     - input stream, LANES bytes per beat
//   out_valid/out_ready/out_data  - output stream, out_data is the main register
//   clear_count  - synchronous clear of mod_count
//   mod_count    - saturating count of bytes altered by conversion
module case_convert_stream
  import case_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int COUNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  input  logic                 clear_count,
  output logic [COUNT_W-1:0]   mod_count
);

  localparam int DW   = 8 * LANES;
  localparam int PC_W = $clog2(LANES + 1);

  // ---------------------------------------------------------------
  // Per-lane conversion of the incoming beat
  // ---------------------------------------------------------------
  logic [DW-1:0]    conv_data;
  logic [LANES-1:0] changed;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    case_lane u_lane (
      .byte_i    (in_data[8*g +: 8]),
      .mode_i    (mode),
      .byte_o    (conv_data[8*g +: 8]),
      .changed_o (changed[g])
    );
  end

  logic [PC_W-1:0] pop_cnt;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      pop_cnt = pop_cnt + PC_W'(changed[i]);
    end
  end

  // ---------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------
  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_ready_q;

  logic accept;
  logic handshake;

  assign accept    = in_valid & in_ready_q;
  assign handshake = out_valid & out_ready;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (accept && !handshake)      state_d = ST_TWO;
        else if (!accept && handshake) state_d = ST_EMPTY;
      end
      // in_ready is low in TWO, so only a drain can happen here.
      ST_TWO:   if (handshake) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      ST_EMPTY: if (accept) main_d = conv_data;
      ST_ONE: begin
        if (accept) begin
          // Draining the same cycle frees main for the new beat; otherwise
          // the in-flight beat is parked in the skid entry.
          if (handshake) main_d = conv_data;
          else           skid_d = conv_data;
        end
      end
      ST_TWO:   if (handshake) main_d = skid_q;
      default: begin
        main_d = main_q;
        skid_d = skid_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  // ---------------------------------------------------------------
  // Saturating modified-byte counter
  // ---------------------------------------------------------------
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W:0]   cnt_sum;

  always_comb begin
    // One extra bit catches the carry out so the count can clamp instead of wrap.
    cnt_sum = {1'b0, cnt_q} + (COUNT_W + 1)'(pop_cnt);
    cnt_d   = cnt_q;
    if (clear_count) begin
      cnt_d = accept ? COUNT_W'(pop_cnt) : '0;
    end else if (accept) begin
      cnt_d = cnt_sum[COUNT_W] ? '1 : cnt_sum[COUNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mod_count = cnt_q;

endmodule

// File: tb/tb_case_convert_stream.sv
// Self-checking bench for case_convert_stream with a queue-based reference model.
// Latency: n/a.
// Backpressure: out_ready is driven directly by the stimulus.
module tb_case_convert_stream;

  localparam int LANES   = 4;
  localparam int COUNT_W = 4;
  localparam int DW      = 8 * LANES;
  localparam int CMAX    = (1 << COUNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         mode;
  logic               in_valid;
  logic               in_ready;
  logic [DW-1:0]      in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic               clear_count;
  logic [COUNT_W-1:0] mod_count;

  always #5 clk = ~clk;

  case_convert_stream #(.LANES(LANES), .COUNT_W(COUNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .clear_count (clear_count),
    .mod_count   (mod_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: beats in flight, expected count, expected ready.
  logic [DW-1:0] exp_q[$];
  int            exp_cnt  = 0;
  bit            exp_rdy  = 1'b0;
  bit            last_acc = 1'b0;
  int            cyc      = 0;
  logic [DW-1:0] out_log[$];
  int            out_cyc[$];

  function automatic logic [7:0] ref_byte(input logic [1:0] m, input logic [7:0] b);
    bit up;
    bit lo;
    up = (b >= 8'd65) && (b <= 8'd90);   // 'A'..'Z'
    lo = (b >= 8'd97) && (b <= 8'd122);  // 'a'..'z'
    if (lo && (m == 2'd1 || m == 2'd3)) return b - 8'd32;
    if (up && (m == 2'd2 || m == 2'd3)) return b + 8'd32;
    return b;
  endfunction

  function automatic logic [DW-1:0] ref_beat(input logic [1:0] m, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[8*i +: 8] = ref_byte(m, d[8*i +: 8]);
    return r;
  endfunction

  function automatic int ref_changes(input logic [1:0] m, input logic [DW-1:0] d);
    int n;
    n = 0;
    for (int i = 0; i < LANES; i++)
      if (ref_byte(m, d[8*i +: 8]) != d[8*i +: 8]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: decide handshakes from the model, advance, then compare.
  task automatic step();
    bit            acc;
    bit            pp;
    logic [DW-1:0] pushed;
    int            nchg;
    acc    = in_valid && exp_rdy && !rst;
    pp     = (exp_q.size() != 0) && out_ready && !rst;
    pushed = ref_beat(mode, in_data);
    nchg   = ref_changes(mode, in_data);
    if (pp) begin
      out_log.push_back(out_data);
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    last_acc = acc;
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
      exp_rdy = 1'b0;
      chk("rst_out_data", out_data, 32'h0);
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(pushed);
      if (clear_count)  exp_cnt = acc ? nchg : 0;
      else if (acc)     exp_cnt = (exp_cnt + nchg > CMAX) ? CMAX : exp_cnt + nchg;
      exp_rdy = (exp_q.size() != 2);
    end
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("in_ready", in_ready, exp_rdy);
    chk("mod_count", mod_count, exp_cnt);
    if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] edges [8];
    edges = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B};
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(65, 90));
      1:       return 8'($urandom_range(97, 122));
      2:       return edges[$urandom_range(0, 7)];
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [DW-1:0] mbeat;
    logic [1:0]    mlist [4];
    logic [DW-1:0] mexp  [4];
    int            cexp  [4];
    logic [DW-1:0] bp    [5];
    int            idx;

    rst = 1'b1; mode = 2'd0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; clear_count = 1'b0;

    // Reset state
    step();
    step();
    chk("reset_in_ready_low", in_ready, 1'b0);
    rst = 1'b0;
    step();
    chk("post_reset_in_ready", in_ready, 1'b1);

    // Upper conversion with boundary neighbours '{', '@'
    mode = 2'd1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h7B617A40;
    step();
    chk("upper_data", out_data, 32'h7B415A40);
    chk("upper_count", mod_count, 32'd2);
    in_valid = 1'b0;
    step();

    // All four modes on the same beat, back to back
    mbeat = 32'h486921E9;
    mlist = '{2'd0, 2'd2, 2'd3, 2'd1};
    mexp  = '{32'h486921E9, 32'h686921E9, 32'h684921E9, 32'h484921E9};
    cexp  = '{2, 3, 5, 6};
    for (int k = 0; k < 4; k++) begin
      mode = mlist[k]; in_valid = 1'b1; in_data = mbeat;
      step();
      chk("mode_data", out_data, mexp[k]);
      chk("mode_count", mod_count, cexp[k]);
    end
    in_valid = 1'b0;
    step();

    // Backpressure: 5 beats with the output stalled
    mode = 2'd0; out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) bp[k] = 32'h30303030 + k;
    idx = 0;
    out_log.delete(); out_cyc.delete();
    for (int t = 0; t < 5; t++) begin
      in_data = bp[idx];
      step();
      if (last_acc) idx++;
    end
    chk("bp_accepts", idx, 32'd2);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_hold", out_data, bp[0]);
    out_ready = 1'b1;
    for (int t = 0; t < 20 && out_log.size() < 5; t++) begin
      in_valid = (idx < 5);
      in_data  = (idx < 5) ? bp[idx] : '0;
      step();
      if (last_acc) idx++;
    end
    chk("bp_count", out_log.size(), 32'd5);
    if (out_log.size() == 5) begin
      for (int k = 0; k < 5; k++) chk("bp_order", out_log[k], bp[k]);
      chk("bp_gapless", out_cyc[4] - out_cyc[0], 32'd4);
    end
    in_valid = 1'b0;
    step();

    // Counter saturation and clear-with-accept
    clear_count = 1'b1;
    step();
    chk("clear_alone", mod_count, 32'd0);
    clear_count = 1'b0; mode = 2'd1; in_valid = 1'b1; in_data = 32'h61626364;
    repeat (5) step();
    chk("count_saturated", mod_count, 32'd15);
    clear_count = 1'b1; in_data = 32'h61622163;
    step();
    chk("clear_with_accept", mod_count, 32'd3);
    clear_count = 1'b0; in_valid = 1'b0;
    step();

    // Reset with the buffer full
    mode = 2'd0; out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hAAAA0001;
    step();
    in_data = 32'hAAAA0002;
    step();
    chk("two_in_ready", in_ready, 1'b0);
    rst = 1'b1; in_valid = 1'b0;
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_mod_count", mod_count, 32'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    step();
    chk("rst_release_ready", in_ready, 1'b1);
    out_ready = 1'b1; in_valid = 1'b1; mode = 2'd1; in_data = 32'h00616263;
    step();
    chk("fresh_valid", out_valid, 1'b1);
    chk("fresh_data", out_data, 32'h00414243);
    in_valid = 1'b0;
    step();

    // Randomized traffic against the model
    for (int t = 0; t < 1500; t++) begin
      rst         = ($urandom_range(0, 99) < 2);
      mode        = 2'($urandom_range(0, 3));
      in_valid    = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < LANES; i++) in_data[8*i +: 8] = rand_byte();
      out_ready   = ($urandom_range(0, 3) != 0);
      clear_count = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
